// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: load, shift, rotate and arithmetic shift with serial I/O.
// A saturating shift counter pulses word_done once a full word has moved since the last load.
module univ_shift_reg #(
  parameter int unsigned             WIDTH       = 8,
  parameter logic [WIDTH-1:0]        RESET_VALUE = '0,
  parameter int unsigned             CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [2:0] ModeHold = 3'b000;
  localparam logic [2:0] ModeLoad = 3'b001;
  localparam logic [2:0] ModeShl  = 3'b010;
  localparam logic [2:0] ModeShr  = 3'b011;
  localparam logic [2:0] ModeRol  = 3'b100;
  localparam logic [2:0] ModeRor  = 3'b101;
  localparam logic [2:0] ModeAsr  = 3'b110;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shifting;

  always_comb begin
    q_d      = q_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (clr) begin
      q_d   = RESET_VALUE;
      cnt_d = '0;
    end else if (en) begin
      case (mode)
        ModeHold: q_d = q_q;
        ModeLoad: begin
          q_d   = d;
          cnt_d = '0;
        end
        ModeShl: begin
          q_d      = {q_q[WIDTH-2:0], sin_r};
          shifting = 1'b1;
        end
        ModeShr: begin
          q_d      = {sin_l, q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        ModeRol: begin
          q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shifting = 1'b1;
        end
        ModeRor: begin
          q_d      = {q_q[0], q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        ModeAsr: begin
          q_d      = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        default: q_d = q_q;
      endcase
      // Counter saturates at WIDTH; the pulse fires only on the WIDTH-1 -> WIDTH step.
      if (shifting && (cnt_q != CntMax)) begin
        cnt_d  = cnt_q + 1'b1;
        done_d = (cnt_q == CntMax - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = q_q;
  assign sout_l    = q_q[WIDTH-1];
  assign sout_r    = q_q[0];
  assign shift_cnt = cnt_q;
  assign word_done = done_q;

endmodule
